// File: rtl/fp_to_int.sv
// fp_to_int: IEEE-754 single to signed 32-bit integer, truncating toward zero.
// Exact left shifts and special cases finish at accept; right shifts run STEP bits per cycle.
module fp_to_int #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [4:0] STEP_W = 5'(STEP);

    state_t      state;
    logic [31:0] mag;
    logic [4:0]  n;
    logic        sticky;
    logic        sign;

    logic [7:0]  ex;
    logic [22:0] frac;
    logic [23:0] m;
    logic [31:0] lsh;
    logic [31:0] acc_data;
    logic [2:0]  acc_flags;
    logic        acc_shift;
    logic [4:0]  k;
    logic [31:0] lost_mask;
    logic [31:0] sh_mag;
    logic        sh_sticky;
    logic [31:0] sh_res;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Decode of the operand presented at accept; every path except the right shift resolves here.
    always_comb begin
        ex        = in_data[30:23];
        frac      = in_data[22:0];
        m         = (ex != '0) ? {1'b1, frac} : 24'd0;
        lsh       = {8'd0, m} << (ex - 8'd150);
        acc_data  = '0;
        acc_flags = '0;
        acc_shift = 1'b0;
        if (ex == 8'hFF) begin
            acc_data  = (frac != '0 || !in_data[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
            acc_flags = 3'b100;
        end else if (ex < 8'd127) begin
            acc_flags = {1'b0, (ex != '0) || (frac != '0), 1'b1};
        end else if (ex >= 8'd158) begin
            acc_data  = in_data[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            acc_flags = (in_data == 32'hCF00_0000) ? 3'b000 : 3'b100;
        end else if (ex >= 8'd150) begin
            acc_data  = in_data[31] ? -lsh : lsh;
        end else begin
            acc_shift = 1'b1;
        end
    end

    always_comb begin
        k         = (n < STEP_W) ? n : STEP_W;
        lost_mask = (32'd1 << k) - 32'd1;
        sh_mag    = mag >> k;
        sh_sticky = sticky | (|(mag & lost_mask));
        sh_res    = sign ? -sh_mag : sh_mag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mag       <= '0;
            n         <= '0;
            sticky    <= 1'b0;
            sign      <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign <= in_data[31];
                    if (acc_shift) begin
                        mag    <= {8'd0, m};
                        n      <= 5'(8'd150 - ex);
                        sticky <= 1'b0;
                        state  <= SHIFT;
                    end else begin
                        out_data  <= acc_data;
                        out_flags <= acc_flags;
                        state     <= DONE;
                    end
                end
                SHIFT: begin
                    mag    <= sh_mag;
                    sticky <= sh_sticky;
                    n      <= n - k;
                    if (n == k) begin
                        out_data  <= sh_res;
                        out_flags <= {1'b0, sh_sticky, sh_res == '0};
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fp_to_int.md
FP_TO_INT -- requirements
Module: fp_to_int

Interface
REQ-001 Parameter STEP, default 1, right-shift bits per SHIFT cycle; legal 1, 2, 4, 8.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous reset, active-low.
REQ-004 in_valid  input  1  in_data valid.
REQ-005 in_ready  output  1  block can accept an operand.
REQ-006 in_data  input  32  IEEE-754 single: sign [31], exponent [30:23], fraction [22:0].
REQ-007 out_valid  output  1  out_data and out_flags valid.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 out_data  output  32  signed two's-complement integer result.
REQ-010 out_flags  output  3  {invalid, inexact, zero}.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM has three states: IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 Accept occurs on a cycle with in_valid && in_ready; operand fields are registered at accept; in_data is ignored at all other times.
REQ-014 Decode at accept: E = in_data[30:23]; M = {1,frac} when E!=0; denormal (E==0) is treated as M=0 with inexact = |frac.
REQ-015 E==255, frac!=0 (NaN) -> result 0x7FFFFFFF, invalid=1; IDLE->DONE.
REQ-016 E==255, frac==0 (infinity) -> result 0x7FFFFFFF for +inf and 0x80000000 for -inf, invalid=1; IDLE->DONE.
REQ-017 Unbiased e = E-127 (signed 9-bit); e<0 -> result 0, inexact = (M!=0), zero=1; IDLE->DONE.
REQ-018 e>=31 -> overflow: result 0x7FFFFFFF if sign=0, else 0x80000000; invalid=1, except an operand of exactly 0xCF000000, which gives 0x80000000 with all flags clear.
REQ-019 23<=e<=30 -> magnitude = M << (e-23), computed in the accept cycle, exact; IDLE->DONE.
REQ-020 0<=e<=22 -> load 32-bit magnitude register with M; remaining count n = 23-e; IDLE->SHIFT.
REQ-021 Each SHIFT cycle shifts right by min(STEP, n), ORs all shifted-out bits into sticky, and decrements n by the same amount.
REQ-022 When n reaches 0, the next state is DONE; inexact = sticky.
REQ-023 Sign application (two's complement when sign=1) happens on the transition into DONE, in the same cycle for every path; rounding is truncation toward zero.
REQ-024 zero flag = (out_data==0); invalid and zero are never both 1.
REQ-025 Latency from the accept edge to out_valid: 1 cycle for non-SHIFT paths; 1+ceil((23-e)/STEP) cycles otherwise (24 cycles max at STEP=1).
REQ-026 DONE holds out_data, out_flags and out_valid stable until out_ready=1.
REQ-027 DONE && out_ready -> IDLE, so in_ready rises the next cycle; there is no accept in the same cycle as result hand-off (at most one operation in flight).
REQ-028 out_data and out_flags are registered outputs with no combinational path from in_data or out_ready.

Reset
REQ-029 rst_n low forces immediately, without waiting for clk: state=IDLE, out_valid=0, in_ready=1 (rises once state is IDLE), busy=0, out_data=0, out_flags=0, n=0, sticky=0.
REQ-030 Reset during SHIFT or DONE discards the operation; no out_valid follows after release.
REQ-031 The first accept is possible on the first rising edge with rst_n high.

Verification
REQ-032 STEP=1, in_data 0x3F800000 (1.0) -> out_data 0x00000001, flags 000, out_valid 24 cycles after accept.
REQ-033 in_data 0xC0200000 (-2.5) -> out_data 0xFFFFFFFE, flags 010; 0x3F000000 (0.5) -> out_data 0, flags 011, latency 1.
REQ-034 in_data 0x4F000000 -> 0x7FFFFFFF flags 100; 0xCF000000 -> 0x80000000 flags 000; 0x7FC00000 -> 0x7FFFFFFF flags 100, latency 1; 0xFF800000 -> 0x80000000 flags 100.
REQ-035 in_data 0x4B000001 (e=23) -> 0x00800001 flags 000, latency 1; 0x4EFFFFFF -> 0x7FFFFF80 flags 000.
REQ-036 out_ready held low 10 cycles in DONE -> out_data stable, in_ready=0, new in_valid ignored; release -> one hand-off, then in_ready=1.
REQ-037 rst_n pulsed low mid-SHIFT -> out_valid stays 0, in_ready=1 after release; rerun with STEP=4 on 1.0 -> out_valid 7 cycles after accept.
